// File: rtl/radio_setbus_arbiter_pkg.sv
// Shared defaults and helpers for the settings-bus arbiter slice.
package radio_setbus_arbiter_pkg;

  localparam int DEFAULT_NUM_BUSES = 2;
  localparam int DEFAULT_AWIDTH    = 8;
  localparam int DEFAULT_DWIDTH    = 32;
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Index width for a channel number; a single bus still needs one bit.
  function automatic int src_width(input int num_buses);
    return (num_buses > 1) ? $clog2(num_buses) : 1;
  endfunction

endpackage

// File: rtl/radio_setbus_arbiter_rr_grant.sv
// Combinational round-robin priority encoder: first request at or after
// last_grant+1, wrapping at NUM_BUSES.
module radio_setbus_arbiter_rr_grant
  import radio_setbus_arbiter_pkg::*;
#(
  parameter int NUM_BUSES = DEFAULT_NUM_BUSES,
  parameter int SRC_WIDTH = src_width(NUM_BUSES)
) (
  input  logic [NUM_BUSES-1:0] req,
  input  logic [SRC_WIDTH-1:0] last_grant,
  output logic                 grant_valid,
  output logic [SRC_WIDTH-1:0] grant_idx
);

  int rank;
  int best;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    best        = NUM_BUSES;
    rank        = 0;
    for (int j = 0; j < NUM_BUSES; j++) begin
      // Rank 0 is the channel right after the previous winner.
      rank = (j + NUM_BUSES - 1 - int'(last_grant)) % NUM_BUSES;
      if (req[j] && (rank < best)) begin
        best        = rank;
        grant_valid = 1'b1;
        grant_idx   = SRC_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/radio_setbus_arbiter.sv
// Round-robin arbiter sharing one stallable settings-bus consumer between
// per-channel settings buses, with one-entry holding registers and drop counting.
module radio_setbus_arbiter
  import radio_setbus_arbiter_pkg::*;
#(
  parameter int NUM_BUSES  = DEFAULT_NUM_BUSES,
  parameter int AWIDTH     = DEFAULT_AWIDTH,
  parameter int DWIDTH     = DEFAULT_DWIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  localparam int SRC_WIDTH = src_width(NUM_BUSES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [NUM_BUSES-1:0]        in_set_stb,
  input  logic [NUM_BUSES*AWIDTH-1:0] in_set_addr,
  input  logic [NUM_BUSES*DWIDTH-1:0] in_set_data,
  output logic [NUM_BUSES-1:0]        in_busy,
  input  logic                        ready,
  output logic                        out_set_stb,
  output logic [AWIDTH-1:0]           out_set_addr,
  output logic [DWIDTH-1:0]           out_set_data,
  output logic [SRC_WIDTH-1:0]        out_set_src,
  output logic                        overflow_stb,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  localparam logic [SRC_WIDTH-1:0] LAST_INIT = SRC_WIDTH'(NUM_BUSES - 1);

  logic [NUM_BUSES-1:0] busy_vec;
  logic [NUM_BUSES-1:0] drop_vec;
  logic [AWIDTH-1:0]    held_addr [NUM_BUSES];
  logic [DWIDTH-1:0]    held_data [NUM_BUSES];

  logic                 grant_valid;
  logic                 do_grant;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic [AWIDTH-1:0]    sel_addr;
  logic [DWIDTH-1:0]    sel_data;

  logic [SRC_WIDTH-1:0] last_grant_reg;
  logic                 out_stb_reg;
  logic [AWIDTH-1:0]    out_addr_reg;
  logic [DWIDTH-1:0]    out_data_reg;
  logic [SRC_WIDTH-1:0] out_src_reg;
  logic                 overflow_reg;
  logic [CNT_WIDTH-1:0] drop_count_reg;
  logic [CNT_WIDTH-1:0] drop_count_next;
  logic [CNT_WIDTH:0]   drop_sum;

  radio_setbus_arbiter_rr_grant #(
    .NUM_BUSES (NUM_BUSES),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_rr_grant (
    .req         (busy_vec),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign do_grant = ready && grant_valid && !clear;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUSES; gi++) begin : g_chan
      logic              granted;
      logic              capture;
      logic              valid_reg;
      logic [AWIDTH-1:0] addr_reg;
      logic [DWIDTH-1:0] data_reg;

      // A slot emptied by this cycle's grant can be refilled in the same cycle.
      assign granted = do_grant && (grant_idx == SRC_WIDTH'(gi));
      assign capture = in_set_stb[gi] && (!valid_reg || granted);
      assign drop_vec[gi] = in_set_stb[gi] && valid_reg && !granted && !clear;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          addr_reg  <= '0;
          data_reg  <= '0;
        end else if (clear) begin
          valid_reg <= 1'b0;
        end else if (capture) begin
          valid_reg <= 1'b1;
          addr_reg  <= in_set_addr[gi*AWIDTH +: AWIDTH];
          data_reg  <= in_set_data[gi*DWIDTH +: DWIDTH];
        end else if (granted) begin
          valid_reg <= 1'b0;
        end
      end

      assign busy_vec[gi]  = valid_reg;
      assign held_addr[gi] = addr_reg;
      assign held_data[gi] = data_reg;
    end
  endgenerate

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_BUSES; j++) begin
      if (grant_idx == SRC_WIDTH'(j)) begin
        sel_addr = held_addr[j];
        sel_data = held_data[j];
      end
    end
  end

  // One spare bit catches the carry so the counter can saturate.
  always_comb begin
    drop_sum = {1'b0, drop_count_reg};
    for (int j = 0; j < NUM_BUSES; j++) begin
      drop_sum = drop_sum + (CNT_WIDTH+1)'(drop_vec[j]);
    end
    drop_count_next = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= LAST_INIT;
      out_stb_reg    <= 1'b0;
      out_addr_reg   <= '0;
      out_data_reg   <= '0;
      out_src_reg    <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (clear) begin
      last_grant_reg <= LAST_INIT;
      out_stb_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      out_stb_reg    <= do_grant;
      overflow_reg   <= |drop_vec;
      drop_count_reg <= drop_count_next;
      if (do_grant) begin
        last_grant_reg <= grant_idx;
        out_addr_reg   <= sel_addr;
        out_data_reg   <= sel_data;
        out_src_reg    <= grant_idx;
      end
    end
  end

  assign in_busy      = busy_vec;
  assign out_set_stb  = out_stb_reg;
  assign out_set_addr = out_addr_reg;
  assign out_set_data = out_data_reg;
  assign out_set_src  = out_src_reg;
  assign overflow_stb = overflow_reg;
  assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_radio_setbus_arbiter.sv
// Randomised and directed checks of radio_setbus_arbiter against a queue-level
// reference model, NUM_BUSES=4 with a short drop counter.
module tb_radio_setbus_arbiter;

  localparam int NB      = 4;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int CW      = 8;
  localparam int SW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             ready = 1'b0;
  logic [NB-1:0]    in_set_stb = '0;
  logic [NB*AW-1:0] in_set_addr = '0;
  logic [NB*DW-1:0] in_set_data = '0;
  logic [NB-1:0]    in_busy;
  logic             out_set_stb;
  logic [AW-1:0]    out_set_addr;
  logic [DW-1:0]    out_set_data;
  logic [SW-1:0]    out_set_src;
  logic             overflow_stb;
  logic [CW-1:0]    drop_count;

  int n_vec = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  radio_setbus_arbiter #(
    .NUM_BUSES (NB),
    .AWIDTH    (AW),
    .DWIDTH    (DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_set_stb   (in_set_stb),
    .in_set_addr  (in_set_addr),
    .in_set_data  (in_set_data),
    .in_busy      (in_busy),
    .ready        (ready),
    .out_set_stb  (out_set_stb),
    .out_set_addr (out_set_addr),
    .out_set_data (out_set_data),
    .out_set_src  (out_set_src),
    .overflow_stb (overflow_stb),
    .drop_count   (drop_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slots, rotating pointer, registered outputs.
  bit            m_valid [NB];
  logic [AW-1:0] m_addr [NB];
  logic [DW-1:0] m_data [NB];
  int            m_last = NB - 1;
  bit            m_out_stb = 1'b0;
  logic [AW-1:0] m_out_addr = '0;
  logic [DW-1:0] m_out_data = '0;
  int            m_out_src = 0;
  bit            m_ovf = 1'b0;
  int            m_cnt = 0;

  function automatic logic [NB-1:0] model_busy();
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i] = m_valid[i];
    return v;
  endfunction

  initial begin : model
    int g;
    int drops;
    int c;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
        m_last = NB - 1; m_out_stb = 1'b0; m_out_addr = '0; m_out_data = '0;
        m_out_src = 0; m_ovf = 1'b0; m_cnt = 0;
      end else if (clear) begin
        for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
        m_last = NB - 1; m_out_stb = 1'b0; m_ovf = 1'b0; m_cnt = 0;
      end else begin
        g = -1;
        if (ready) begin
          for (int k = 1; k <= NB; k++) begin
            c = (m_last + k) % NB;
            if (g < 0 && m_valid[c]) g = c;
          end
        end
        m_out_stb = (g >= 0);
        if (g >= 0) begin
          m_out_addr = m_addr[g];
          m_out_data = m_data[g];
          m_out_src  = g;
          m_valid[g] = 1'b0;
          m_last     = g;
        end
        drops = 0;
        for (int i = 0; i < NB; i++) begin
          if (in_set_stb[i]) begin
            if (m_valid[i]) drops++;
            else begin
              m_valid[i] = 1'b1;
              m_addr[i]  = in_set_addr[i*AW +: AW];
              m_data[i]  = in_set_data[i*DW +: DW];
            end
          end
        end
        m_ovf = (drops > 0);
        m_cnt = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_stb",  64'(out_set_stb),  64'(m_out_stb));
      chk("cmp_addr", 64'(out_set_addr), 64'(m_out_addr));
      chk("cmp_data", 64'(out_set_data), 64'(m_out_data));
      chk("cmp_src",  64'(out_set_src),  64'(m_out_src));
      chk("cmp_busy", 64'(in_busy),      64'(model_busy()));
      chk("cmp_ovf",  64'(overflow_stb), 64'(m_ovf));
      chk("cmp_cnt",  64'(drop_count),   64'(m_cnt));
      if (out_set_stb)
        $display("xfer src=%0d addr=%02h data=%08h drops=%0d",
                 out_set_src, out_set_addr, out_set_data, drop_count);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic burst_all(input string tag);
    for (int i = 0; i < NB; i++) begin
      in_set_addr[i*AW +: AW] = AW'(8'h20 + i);
      in_set_data[i*DW +: DW] = DW'(i);
    end
    in_set_stb = '1;
    next();
    in_set_stb = '0;
    next();
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk({tag, "_stb"},  64'(out_set_stb),  64'h1);
      chk({tag, "_src"},  64'(out_set_src),  64'(k));
      chk({tag, "_addr"}, 64'(out_set_addr), 64'(8'h20 + k));
      next();
    end
    @(negedge clk);
    chk({tag, "_idle"}, 64'(out_set_stb), 64'h0);
    next();
  endtask

  initial begin
    int pulses;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_en = 1'b1;
    chk("rst_stb",  64'(out_set_stb), 64'h0);
    chk("rst_busy", 64'(in_busy),     64'h0);
    chk("rst_cnt",  64'(drop_count),  64'h0);
    chk("rst_data", 64'(out_set_data), 64'h0);
    next();

    // Two simultaneous bursts: both served 0,1,2,3.
    burst_all("burstA");
    burst_all("burstB");

    // Single write on channel 0: two-cycle latency.
    in_set_stb = 4'b0001;
    in_set_addr[7:0] = 8'h10;
    in_set_data[31:0] = 32'hDEADBEEF;
    next();
    in_set_stb = '0;
    @(negedge clk);
    chk("t1_busy", 64'(in_busy), 64'h1);
    chk("t1_early", 64'(out_set_stb), 64'h0);
    next();
    @(negedge clk);
    chk("t1_stb",  64'(out_set_stb),  64'h1);
    chk("t1_addr", 64'(out_set_addr), 64'h10);
    chk("t1_data", 64'(out_set_data), 64'hDEADBEEF);
    chk("t1_src",  64'(out_set_src),  64'h0);
    chk("t1_cnt",  64'(drop_count),   64'h0);
    next();

    // Stalled consumer, second write on channel 1 is dropped.
    ready = 1'b0;
    in_set_stb = 4'b0010;
    in_set_data[DW +: DW] = 32'd1;
    next();
    in_set_data[DW +: DW] = 32'd2;
    next();
    in_set_stb = '0;
    @(negedge clk);
    chk("t3_ovf",  64'(overflow_stb), 64'h1);
    chk("t3_cnt",  64'(drop_count),   64'h1);
    chk("t3_busy", 64'(in_busy),      64'h2);
    chk("t3_stall", 64'(out_set_stb), 64'h0);
    next();
    @(negedge clk);
    chk("t3_ovf_once", 64'(overflow_stb), 64'h0);
    ready = 1'b1;
    next();
    @(negedge clk);
    chk("t3_stb",  64'(out_set_stb),  64'h1);
    chk("t3_data", 64'(out_set_data), 64'h1);
    chk("t3_src",  64'(out_set_src),  64'h1);
    next();
    @(negedge clk);
    chk("t3_single", 64'(out_set_stb), 64'h0);
    next();

    // Back-to-back strobes on channel 0: full throughput, no loss.
    pulses = 0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          in_set_stb = 4'b0001;
          in_set_data[31:0] = 32'(1000 + k);
          next();
        end
        in_set_stb = '0;
      end
      begin
        for (int c = 0; c < 106; c++) begin
          @(negedge clk);
          if (out_set_stb) begin
            chk("seq_data", 64'(out_set_data), 64'(1000 + pulses));
            pulses++;
          end
        end
      end
    join
    chk("seq_count", 64'(pulses), 64'd100);
    chk("seq_cnt",   64'(drop_count), 64'h1);
    next();

    // Saturate the drop counter, then clear with a colliding strobe.
    ready = 1'b0;
    for (int k = 0; k < 70; k++) begin
      in_set_stb = '1;
      in_set_data = {$urandom, $urandom, $urandom, $urandom};
      next();
    end
    in_set_stb = '0;
    @(negedge clk);
    chk("sat_cnt", 64'(drop_count), 64'(CNT_MAX));
    next();
    clear = 1'b1;
    in_set_stb = '1;
    next();
    clear = 1'b0;
    in_set_stb = '0;
    @(negedge clk);
    chk("clr_cnt",  64'(drop_count),   64'h0);
    chk("clr_busy", 64'(in_busy),      64'h0);
    chk("clr_stb",  64'(out_set_stb),  64'h0);
    chk("clr_ovf",  64'(overflow_stb), 64'h0);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next();
      @(negedge clk);
      chk("clr_nopulse", 64'(out_set_stb), 64'h0);
    end
    next();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_set_stb  = ((c % 400) < 200) ? NB'($urandom) : NB'($urandom & $urandom);
      ready       = ($urandom_range(0, 3) != 0);
      clear       = ($urandom_range(0, 63) == 0);
      in_set_addr = NB*AW'($urandom);
      in_set_data = {$urandom, $urandom, $urandom, $urandom};
      next();
    end
    in_set_stb = '0;
    clear = 1'b0;

    // Reset while channel 2 is pending behind a stalled consumer.
    ready = 1'b0;
    in_set_stb = 4'b0100;
    in_set_addr[2*AW +: AW] = 8'h5A;
    next();
    in_set_stb = '0;
    @(negedge clk);
    chk("rst2_busy_pre", 64'(in_busy[2]), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst2_stb",  64'(out_set_stb),  64'h0);
    chk("rst2_addr", 64'(out_set_addr), 64'h0);
    chk("rst2_data", 64'(out_set_data), 64'h0);
    chk("rst2_src",  64'(out_set_src),  64'h0);
    chk("rst2_busy", 64'(in_busy),      64'h0);
    chk("rst2_ovf",  64'(overflow_stb), 64'h0);
    chk("rst2_cnt",  64'(drop_count),   64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next();
      @(negedge clk);
      chk("rst2_nostale", 64'(out_set_stb), 64'h0);
    end
    next();
    in_set_stb = 4'b1000;
    in_set_addr[3*AW +: AW] = 8'h77;
    next();
    in_set_stb = '0;
    next();
    @(negedge clk);
    chk("rst2_first_stb",  64'(out_set_stb),  64'h1);
    chk("rst2_first_addr", 64'(out_set_addr), 64'h77);
    chk("rst2_first_src",  64'(out_set_src),  64'h3);
    next();
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
